dot_product_lanes: RTL and testbench

- Parametrised successor to the single-lane streaming dot product.
- Accepts LANES element pairs per beat over a valid/ready input stream, with per-lane masking and a last-beat marker for runtime vector length.
- Supports signed or unsigned operands and delivers one result per vector through a backpressured output.
- Sits between the vector-fetch stream and the result/writeback stage.

---
 rtl/dot_product_lanes_pkg.sv | 35 +++
 rtl/dot_product_lanes_if.sv | 40 ++++
 rtl/dot_product_lanes_adder_tree.sv | 51 +++++
 rtl/dot_product_lanes.sv | 184 ++++++++++++++++++
 tb/tb_dot_product_lanes.sv | 376 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dot_product_lanes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dot_product_pkg
// Brief    : Shared widths, FSM state type and lane-slice helper for
//            dot_product_lanes.
// Revision : 1.0 - initial release
// ============================================================================
package dot_product_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_e;

  // Sized so MAX_LEN full-scale products can never overflow the accumulator.
  function automatic int acc_width(input int width, input int max_len);
    return 2 * width + $clog2(max_len) + 1;
  endfunction

  function automatic int cnt_width(input int max_len);
    return $clog2(max_len) + 1;
  endfunction

  function automatic int pop_width(input int lanes);
    return $clog2(lanes) + 1;
  endfunction

  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dot_product_lanes_if.sv
`default_nettype none
// ============================================================================
// Module   : dot_product_lanes_if
// Brief    : Beat input stream and result output stream of dot_product_lanes.
// Revision : 1.0 - initial release
// ============================================================================
interface dot_product_lanes_if
  import dot_product_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int LANES   = 4,
  parameter int MAX_LEN = 64
);
  localparam int ACC_W = acc_width(WIDTH, MAX_LEN);
  localparam int CNT_W = cnt_width(MAX_LEN);

  logic                   in_valid;
  logic                   in_ready;
  logic                   in_last;
  logic [LANES-1:0]       lane_mask;
  logic [LANES*WIDTH-1:0] a_vec;
  logic [LANES*WIDTH-1:0] b_vec;
  logic                   out_valid;
  logic                   out_ready;
  logic [ACC_W-1:0]       result;
  logic [CNT_W-1:0]       out_count;
  logic                   out_err;

  modport master (
    output in_valid, in_last, lane_mask, a_vec, b_vec, out_ready,
    input  in_ready, out_valid, result, out_count, out_err
  );

  modport slave (
    input  in_valid, in_last, lane_mask, a_vec, b_vec, out_ready,
    output in_ready, out_valid, result, out_count, out_err
  );

endinterface
`default_nettype wire

// File: rtl/dot_product_lanes_adder_tree.sv
`default_nettype none
// ============================================================================
// Module   : dp_adder_tree
// Brief    : LANES-input signed/unsigned adder tree with a registered sum.
// Revision : 1.0 - initial release
// ============================================================================
module dp_adder_tree
  import dot_product_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int IN_W   = 16,
  parameter int OUT_W  = 24,
  parameter int SIGNED = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic [LANES*IN_W-1:0] data_i,
  output logic [OUT_W-1:0]      sum_o
);
  localparam bit SGN = (SIGNED != 0);

  logic [OUT_W-1:0] lane_ext [LANES];
  logic [OUT_W-1:0] sum_d;
  logic [OUT_W-1:0] sum_q;

  for (genvar i = 0; i < LANES; i++) begin : g_ext
    logic [IN_W-1:0] lane;
    assign lane        = data_i[lane_lo(i, IN_W) +: IN_W];
    assign lane_ext[i] = {{(OUT_W-IN_W){SGN & lane[IN_W-1]}}, lane};
  end

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_d = sum_d + lane_ext[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= valid_i ? sum_d : '0;
    end
  end

  assign sum_o = sum_q;

endmodule
`default_nettype wire

// File: rtl/dot_product_lanes.sv
`default_nettype none
// ============================================================================
// Module   : dot_product_lanes
// Brief    : Multi-lane streaming dot product, masked lanes, runtime length,
//            backpressured result. Optional clamp on length overflow when
//            DOT_PRODUCT_LANES_SAT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module dot_product_lanes
  import dot_product_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int LANES   = 4,
  parameter int MAX_LEN = 64,
  parameter int SIGNED  = 0
) (
  input  logic               clk,
  input  logic               rst,
  dot_product_lanes_if.slave dp_if
);
  localparam int ACC_W  = acc_width(WIDTH, MAX_LEN);
  localparam int CNT_W  = cnt_width(MAX_LEN);
  localparam int POP_W  = pop_width(LANES);
  localparam int PROD_W = 2 * WIDTH;
  localparam bit SGN    = (SIGNED != 0);
`ifdef DOT_PRODUCT_LANES_SAT_EN
  // Guard bits let the clamp see the true sign/magnitude after an overflow.
  localparam int GUARD_W = 8;
`else
  localparam int GUARD_W = 0;
`endif
  localparam int SUM_W = ACC_W + GUARD_W;
  localparam logic [CNT_W:0]   MAX_CNT  = (CNT_W+1)'(MAX_LEN);
  localparam logic [CNT_W-1:0] MAX_CNTN = CNT_W'(MAX_LEN);

  logic                    accept;
  logic [LANES*PROD_W-1:0] prod_d, prod_q;
  logic [POP_W-1:0]        pop_d, pop1_q, pop2_q;
  logic                    v1_q, v2_q;
  logic [SUM_W-1:0]        sum_q;
  state_e                  state_q;
  logic                    drain_q;
  logic [SUM_W-1:0]        acc_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W:0]          cnt_sum_d;
  logic                    cnt_ovf_d;
  logic                    err_q;
  logic                    out_valid_q;

  assign dp_if.in_ready = !rst && (state_q == IDLE || state_q == ACCUM);
  assign accept         = dp_if.in_valid && dp_if.in_ready;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [WIDTH-1:0]  a_l, b_l;
    logic [PROD_W-1:0] a_x, b_x;
    assign a_l = dp_if.a_vec[lane_lo(i, WIDTH) +: WIDTH];
    assign b_l = dp_if.b_vec[lane_lo(i, WIDTH) +: WIDTH];
    // Extending to the product width first makes the truncated multiply exact
    // for both two's-complement and unsigned operands.
    assign a_x = {{WIDTH{SGN & a_l[WIDTH-1]}}, a_l};
    assign b_x = {{WIDTH{SGN & b_l[WIDTH-1]}}, b_l};
    assign prod_d[lane_lo(i, PROD_W) +: PROD_W] = dp_if.lane_mask[i] ? a_x * b_x : '0;
  end

  always_comb begin
    pop_d = '0;
    for (int i = 0; i < LANES; i++) begin
      pop_d = pop_d + POP_W'(dp_if.lane_mask[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      prod_q <= '0;
      pop1_q <= '0;
      v2_q   <= 1'b0;
      pop2_q <= '0;
    end else begin
      v1_q   <= accept;
      prod_q <= accept ? prod_d : '0;
      pop1_q <= accept ? pop_d : '0;
      v2_q   <= v1_q;
      pop2_q <= v1_q ? pop1_q : '0;
    end
  end

  dp_adder_tree #(
    .LANES  (LANES),
    .IN_W   (PROD_W),
    .OUT_W  (SUM_W),
    .SIGNED (SIGNED)
  ) u_tree (
    .clk     (clk),
    .rst     (rst),
    .valid_i (v1_q),
    .data_i  (prod_q),
    .sum_o   (sum_q)
  );

  always_comb begin
    cnt_sum_d = {1'b0, cnt_q} + (CNT_W+1)'(pop2_q);
    cnt_ovf_d = (cnt_sum_d > MAX_CNT);
    cnt_d     = cnt_ovf_d ? MAX_CNTN : cnt_sum_d[CNT_W-1:0];
  end

  // Two-cycle DRAIN matches the product + tree register depth, so the last
  // beat lands in the accumulator on the same edge out_valid rises.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      drain_q     <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (v2_q) begin
        acc_q <= acc_q + sum_q;
        cnt_q <= cnt_d;
        if (cnt_ovf_d) begin
          err_q <= 1'b1;
        end
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= dp_if.in_last ? DRAIN : ACCUM;
          end
        end
        ACCUM: begin
          if (accept && dp_if.in_last) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          drain_q <= !drain_q;
          if (drain_q) begin
            state_q     <= HOLD;
            out_valid_q <= 1'b1;
          end
        end
        HOLD: begin
          if (dp_if.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dp_if.out_valid = out_valid_q;
  assign dp_if.out_count = cnt_q;
  assign dp_if.out_err   = err_q;

`ifdef DOT_PRODUCT_LANES_SAT_EN
  logic [GUARD_W:0] top_bits;
  logic             wrapped;
  logic             neg;
  logic [ACC_W-1:0] clamp;

  assign top_bits = acc_q[SUM_W-1:ACC_W-1];
  assign wrapped  = SGN ? !((&top_bits) || !(|top_bits)) : (|top_bits[GUARD_W:1]);
  assign neg      = SGN & acc_q[SUM_W-1];

  always_comb begin
    clamp = '1;
    if (SGN) begin
      clamp = neg ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  assign dp_if.result = (err_q && wrapped) ? clamp : acc_q[ACC_W-1:0];
`else
  assign dp_if.result = acc_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dot_product_lanes.sv
`default_nettype none
// ============================================================================
// Module   : tb_dot_product_lanes
// Brief    : Self-checking bench, unsigned (MAX_LEN=8) and signed (MAX_LEN=64)
//            instances against a plain-arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dot_product_lanes;
  localparam int W    = 8;
  localparam int L    = 4;
  localparam int ML_U = 8;
  localparam int ML_S = 64;
  localparam int AW_U = dot_product_pkg::acc_width(W, ML_U);
  localparam int AW_S = dot_product_pkg::acc_width(W, ML_S);

  typedef int lane_t [L];

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dot_product_lanes_if #(.WIDTH(W), .LANES(L), .MAX_LEN(ML_U)) if_u ();
  dot_product_lanes_if #(.WIDTH(W), .LANES(L), .MAX_LEN(ML_S)) if_s ();

  dot_product_lanes #(.WIDTH(W), .LANES(L), .MAX_LEN(ML_U), .SIGNED(0)) u_dut_u (
    .clk(clk), .rst(rst), .dp_if(if_u)
  );
  dot_product_lanes #(.WIDTH(W), .LANES(L), .MAX_LEN(ML_S), .SIGNED(1)) u_dut_s (
    .clk(clk), .rst(rst), .dp_if(if_s)
  );

  int     n_cmp = 0;
  int     n_bad = 0;
  longint ref_sum = 0;
  int     ref_cnt = 0;

  function automatic logic rdy(input bit s);
    return s ? if_s.in_ready : if_u.in_ready;
  endfunction
  function automatic logic ovld(input bit s);
    return s ? if_s.out_valid : if_u.out_valid;
  endfunction
  function automatic longint res(input bit s);
    if (s) return longint'($signed(if_s.result));
    return longint'(if_u.result);
  endfunction
  function automatic int cnt(input bit s);
    return s ? int'(if_s.out_count) : int'(if_u.out_count);
  endfunction
  function automatic logic err(input bit s);
    return s ? if_s.out_err : if_u.out_err;
  endfunction

  function automatic int ml(input bit s);
    return s ? ML_S : ML_U;
  endfunction
  function automatic int exp_cnt(input bit s);
    return (ref_cnt > ml(s)) ? ml(s) : ref_cnt;
  endfunction
  function automatic logic exp_err(input bit s);
    return ref_cnt > ml(s);
  endfunction
  function automatic longint exp_res(input bit s);
    int     aw;
    longint full, m;
    aw   = s ? AW_S : AW_U;
    full = longint'(1) << aw;
    m    = ref_sum % full;
    if (m < 0) m += full;
    if (s && m >= full / 2) m -= full;
`ifdef DOT_PRODUCT_LANES_SAT_EN
    if (ref_cnt > ml(s) && m != ref_sum)
      m = s ? ((ref_sum < 0) ? -(full / 2) : (full / 2 - 1)) : (full - 1);
`endif
    return m;
  endfunction

  task automatic set_in(input bit s, input logic v, input logic last, input logic [L-1:0] m,
                        input logic [L*W-1:0] av, input logic [L*W-1:0] bv);
    if (s) begin
      if_s.in_valid = v; if_s.in_last = last; if_s.lane_mask = m; if_s.a_vec = av; if_s.b_vec = bv;
    end else begin
      if_u.in_valid = v; if_u.in_last = last; if_u.lane_mask = m; if_u.a_vec = av; if_u.b_vec = bv;
    end
  endtask

  task automatic drive_beat(input bit s, input lane_t a, input lane_t b, input logic [L-1:0] m,
                            input logic last, output int waited);
    logic [L*W-1:0] av, bv;
    for (int i = 0; i < L; i++) begin
      av[i*W +: W] = W'(a[i]);
      bv[i*W +: W] = W'(b[i]);
      if (m[i]) ref_sum += longint'(a[i]) * longint'(b[i]);
    end
    ref_cnt += $countones(m);
    @(negedge clk);
    set_in(s, 1'b1, last, m, av, bv);
    waited = 0;
    while (!rdy(s) && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!rdy(s)) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: in_ready=0 after %0d cycles, required 1", waited);
    end
    @(posedge clk);
    #1;
    set_in(s, 1'b0, 1'b0, '0, av, bv);
  endtask

  // Idle cycles with in_last raised but in_valid low; the DUT must ignore them.
  task automatic bubble(input bit s, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      set_in(s, 1'b0, 1'b1, L'($urandom), (L*W)'($urandom), (L*W)'($urandom));
    end
  endtask

  task automatic wait_valid(input bit s, output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while (!ovld(s) && n < 30) begin
      @(negedge clk);
      n++;
    end
    ok = ovld(s);
  endtask

  task automatic handshake(input bit s);
    @(negedge clk);
    if (s) if_s.out_ready = 1'b1; else if_u.out_ready = 1'b1;
    @(posedge clk);
    #1;
    if_s.out_ready = 1'b0;
    if_u.out_ready = 1'b0;
    ref_sum = 0;
    ref_cnt = 0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_cmp++; if (if_u.in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %b need 0", if_u.in_ready); end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (if_u.in_ready !== 1'b1) begin n_bad++; $display("FAIL post_rst_in_ready_u: got %b need 1", if_u.in_ready); end
    n_cmp++; if (if_s.in_ready !== 1'b1) begin n_bad++; $display("FAIL post_rst_in_ready_s: got %b need 1", if_s.in_ready); end
    n_cmp++; if (if_u.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b need 0", if_u.out_valid); end
    n_cmp++; if (res(0) !== 0) begin n_bad++; $display("FAIL rst_result: got %0d need 0", res(0)); end
    n_cmp++; if (cnt(0) !== 0) begin n_bad++; $display("FAIL rst_count: got %0d need 0", cnt(0)); end
    n_cmp++; if (err(0) !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b need 0", err(0)); end
  endtask

  task automatic test_single_beat;
    lane_t a, b;
    int    w;
    a = '{1, 2, 3, 4};
    b = '{10, 1, 0, 2};
    drive_beat(0, a, b, 4'hF, 1'b1, w);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (ovld(0) !== (k == 2)) begin
        n_bad++; $display("FAIL latency_t%0d: out_valid=%b need %b", k, ovld(0), (k == 2));
      end
    end
    n_cmp++; if (res(0) !== 20) begin n_bad++; $display("FAIL single_result: got %0d need 20", res(0)); end
    n_cmp++; if (cnt(0) !== 4) begin n_bad++; $display("FAIL single_count: got %0d need 4", cnt(0)); end
    n_cmp++; if (err(0) !== 1'b0) begin n_bad++; $display("FAIL single_err: got %b need 0", err(0)); end
    handshake(0);
  endtask

  task automatic test_backpressure;
    lane_t a, b;
    int    w;
    bit    ok;
    a = '{255, 255, 255, 255};
    b = '{1, 1, 1, 1};
    drive_beat(0, a, b, 4'hF, 1'b0, w);
    drive_beat(0, a, b, 4'h3, 1'b1, w);
    wait_valid(0, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL bp_valid: out_valid=0 after 30 cycles, need 1"); end
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (res(0) !== 1530) begin n_bad++; $display("FAIL bp_result_c%0d: got %0d need 1530", k, res(0)); end
      n_cmp++; if (cnt(0) !== 6) begin n_bad++; $display("FAIL bp_count_c%0d: got %0d need 6", k, cnt(0)); end
      n_cmp++; if (rdy(0) !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready_c%0d: got %b need 0", k, rdy(0)); end
      @(negedge clk);
    end
    handshake(0);
    @(negedge clk);
    n_cmp++; if (ovld(0) !== 1'b0) begin n_bad++; $display("FAIL bp_valid_drop: got %b need 0", ovld(0)); end
    n_cmp++; if (rdy(0) !== 1'b1) begin n_bad++; $display("FAIL bp_ready_back: got %b need 1", rdy(0)); end
  endtask

  task automatic test_signed;
    lane_t a, b;
    int    w;
    bit    ok;
    a = '{-128, -1, 5, 0};
    b = '{127, -1, -3, 9};
    drive_beat(1, a, b, 4'hF, 1'b1, w);
    wait_valid(1, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL signed_valid: out_valid=0 after 30 cycles, need 1"); end
    n_cmp++; if (res(1) !== -16270) begin n_bad++; $display("FAIL signed_result: got %0d need -16270", res(1)); end
    n_cmp++; if (cnt(1) !== 4) begin n_bad++; $display("FAIL signed_count: got %0d need 4", cnt(1)); end
    handshake(1);
  endtask

  task automatic test_masked;
    lane_t a, b;
    int    w;
    bit    ok;
    a = '{5, 6, 7, 8};
    b = '{1, 1, 1, 1};
    drive_beat(0, a, b, 4'b1010, 1'b1, w);
    wait_valid(0, ok);
    n_cmp++; if (res(0) !== 14 || !ok) begin n_bad++; $display("FAIL mask_result: got %0d need 14", res(0)); end
    n_cmp++; if (cnt(0) !== 2) begin n_bad++; $display("FAIL mask_count: got %0d need 2", cnt(0)); end
    handshake(0);
    drive_beat(0, a, b, 4'b0000, 1'b1, w);
    wait_valid(0, ok);
    n_cmp++; if (res(0) !== 0 || !ok) begin n_bad++; $display("FAIL empty_result: got %0d need 0", res(0)); end
    n_cmp++; if (cnt(0) !== 0) begin n_bad++; $display("FAIL empty_count: got %0d need 0", cnt(0)); end
    n_cmp++; if (err(0) !== 1'b0) begin n_bad++; $display("FAIL empty_err: got %b need 0", err(0)); end
    handshake(0);
  endtask

  task automatic test_overflow;
    lane_t a, b;
    int    w;
    bit    ok;
    longint need;
    a = '{1, 1, 1, 1};
    for (int k = 0; k < 3; k++) drive_beat(0, a, a, 4'hF, (k == 2), w);
    wait_valid(0, ok);
    n_cmp++; if (res(0) !== 12 || !ok) begin n_bad++; $display("FAIL ovf_result: got %0d need 12", res(0)); end
    n_cmp++; if (cnt(0) !== 8) begin n_bad++; $display("FAIL ovf_count: got %0d need 8", cnt(0)); end
    n_cmp++; if (err(0) !== 1'b1) begin n_bad++; $display("FAIL ovf_err: got %b need 1", err(0)); end
    handshake(0);
    a = '{255, 255, 255, 255};
    for (int k = 0; k < 5; k++) drive_beat(0, a, a, 4'hF, (k == 4), w);
`ifdef DOT_PRODUCT_LANES_SAT_EN
    need = 1048575;
`else
    need = 251924;
`endif
    wait_valid(0, ok);
    n_cmp++; if (res(0) !== need || !ok) begin n_bad++; $display("FAIL wrap_result: got %0d need %0d", res(0), need); end
    n_cmp++; if (err(0) !== 1'b1) begin n_bad++; $display("FAIL wrap_err: got %b need 1", err(0)); end
    handshake(0);
  endtask

  task automatic test_back_to_back;
    lane_t  a, b;
    int     w;
    bit     ok;
    longint e_res;
    int     e_cnt;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < L; i++) begin
        a[i] = int'($urandom_range(255)) - 128;
        b[i] = int'($urandom_range(255)) - 128;
      end
      drive_beat(1, a, b, 4'hF, (k == 2), w);
      if (k < 2) bubble(1, 2);
    end
    e_res = exp_res(1);
    e_cnt = exp_cnt(1);
    wait_valid(1, ok);
    n_cmp++; if (res(1) !== e_res || !ok) begin n_bad++; $display("FAIL b2b_v1_result: got %0d need %0d", res(1), e_res); end
    n_cmp++; if (cnt(1) !== e_cnt) begin n_bad++; $display("FAIL b2b_v1_count: got %0d need %0d", cnt(1), e_cnt); end
    handshake(1);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < L; i++) begin
        a[i] = int'($urandom_range(255)) - 128;
        b[i] = int'($urandom_range(255)) - 128;
      end
      drive_beat(1, a, b, 4'hF, (k == 1), w);
      if (k == 0) begin
        n_cmp++; if (w !== 0) begin n_bad++; $display("FAIL b2b_stall: waited %0d cycles need 0", w); end
      end
    end
    e_res = exp_res(1);
    wait_valid(1, ok);
    n_cmp++; if (res(1) !== e_res || !ok) begin n_bad++; $display("FAIL b2b_v2_result: got %0d need %0d", res(1), e_res); end
    n_cmp++; if (cnt(1) !== 8) begin n_bad++; $display("FAIL b2b_v2_count: got %0d need 8", cnt(1)); end
    handshake(1);
  endtask

  task automatic test_abort;
    lane_t a;
    int    w;
    bit    ok;
    a = '{3, 3, 3, 3};
    drive_beat(0, a, a, 4'hF, 1'b0, w);
    drive_beat(0, a, a, 4'hF, 1'b0, w);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    ref_sum = 0;
    ref_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_cmp++; if (ovld(0) !== 1'b0) begin n_bad++; $display("FAIL abort_valid_c%0d: got %b need 0", k, ovld(0)); end
    end
    n_cmp++; if (cnt(0) !== 0) begin n_bad++; $display("FAIL abort_count: got %0d need 0", cnt(0)); end
    a = '{1, 1, 1, 1};
    drive_beat(0, a, a, 4'hF, 1'b1, w);
    wait_valid(0, ok);
    n_cmp++; if (res(0) !== 4 || !ok) begin n_bad++; $display("FAIL abort_next_result: got %0d need 4", res(0)); end
    handshake(0);
  endtask

  task automatic test_random;
    lane_t          a, b;
    bit             s, ok;
    int             nb, w, e_cnt;
    logic           e_err;
    longint         e_res;
    logic [L-1:0]   m;
    for (int v = 0; v < 16; v++) begin
      s  = 1'($urandom_range(1));
      nb = s ? int'($urandom_range(6, 1)) : int'($urandom_range(3, 1));
      for (int k = 0; k < nb; k++) begin
        for (int i = 0; i < L; i++) begin
          a[i] = s ? int'($urandom_range(255)) - 128 : int'($urandom_range(255));
          b[i] = s ? int'($urandom_range(255)) - 128 : int'($urandom_range(255));
        end
        m = L'($urandom);
        drive_beat(s, a, b, m, (k == nb - 1), w);
        if ($urandom_range(3) == 0) bubble(s, int'($urandom_range(3, 1)));
      end
      e_res = exp_res(s);
      e_cnt = exp_cnt(s);
      e_err = exp_err(s);
      wait_valid(s, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL rnd%0d_valid: out_valid=0 after 30 cycles, need 1", v); end
      n_cmp++; if (res(s) !== e_res) begin n_bad++; $display("FAIL rnd%0d_result: got %0d need %0d", v, res(s), e_res); end
      n_cmp++; if (cnt(s) !== e_cnt) begin n_bad++; $display("FAIL rnd%0d_count: got %0d need %0d", v, cnt(s), e_cnt); end
      n_cmp++; if (err(s) !== e_err) begin n_bad++; $display("FAIL rnd%0d_err: got %b need %b", v, err(s), e_err); end
      repeat ($urandom_range(3)) begin
        @(negedge clk);
        n_cmp++; if (res(s) !== e_res) begin n_bad++; $display("FAIL rnd%0d_hold: got %0d need %0d", v, res(s), e_res); end
      end
      handshake(s);
    end
  endtask

  initial begin
    set_in(0, 1'b0, 1'b0, '0, '0, '0);
    set_in(1, 1'b0, 1'b0, '0, '0, '0);
    if_u.out_ready = 1'b0;
    if_s.out_ready = 1'b0;
    test_reset();
    test_single_beat();
    test_backpressure();
    test_signed();
    test_masked();
    test_overflow();
    test_back_to_back();
    test_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
